// File: rtl/elevator_pkg.sv
// elevator_pkg: types shared by the floor scheduler and the motion FSM.
// State and direction encodings must stay in step with the motion FSM.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } sched_state_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  // counter width able to hold n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// elevator_scheduler_if: call inputs and car status of the floor scheduler.
// master is the call panel / motion side, slave is the scheduler.
interface elevator_scheduler_if #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 3
) ();

  logic [FLOORS-1:0]  call_req;
  logic [FLOOR_W-1:0] cur_floor;
  logic               move_up;
  logic               move_down;
  logic               door_open;
  logic [FLOORS-1:0]  pending;
  logic               busy;

  modport master (
    output call_req,
    input  cur_floor,
    input  move_up,
    input  move_down,
    input  door_open,
    input  pending,
    input  busy
  );

  modport slave (
    input  call_req,
    output cur_floor,
    output move_up,
    output move_down,
    output door_open,
    output pending,
    output busy
  );

endinterface

// File: rtl/down_timer.sv
// down_timer: loadable down-counter that parks at zero.
// zero is decoded from the register, so it is glitch-free.
module down_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // load has priority; otherwise count down and hold at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN floor scheduler above the motion FSM.
// Latches calls, times travel and door dwell, picks direction.
import elevator_pkg::*;

module elevator_scheduler #(
  parameter int FLOORS        = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input logic                 clk,
  input logic                 rst,
  elevator_scheduler_if.slave bus
);

  localparam int TW = cnt_w(TRAVEL_CYCLES);
  localparam int DW = cnt_w(DOOR_CYCLES);
  localparam logic [TW-1:0] TLOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DLOAD = DW'(DOOR_CYCLES - 1);

  sched_state_t       state_q;
  sched_state_t       state_d;
  dir_t               dir_q;
  logic [FLOOR_W-1:0] floor_q;
  logic [FLOOR_W-1:0] nxt_floor;
  logic [FLOORS-1:0]  pend_q;
  logic [FLOORS-1:0]  clr;
  logic [FLOORS-1:0]  cur_oh;
  logic [FLOORS-1:0]  nxt_oh;
  logic               above;
  logic               below;
  logic               here;
  logic               nxt_hit;
  logic               call_here;
  logic               moving;
  logic               step;
  logic               travel_load;
  logic               travel_zero;
  logic               door_load;
  logic               door_zero;

  assign moving = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);

  // next floor only matters while moving; it never wraps there
  assign nxt_floor = (state_q == MOVE_DOWN) ?
                     floor_q - FLOOR_W'(1) :
                     floor_q + FLOOR_W'(1);

  // floor masks and the above/below summary of latched calls
  always_comb begin
    above  = 1'b0;
    below  = 1'b0;
    cur_oh = '0;
    nxt_oh = '0;
    for (int i = 0; i < FLOORS; i++) begin
      cur_oh[i] = (i == int'(floor_q));
      nxt_oh[i] = (i == int'(nxt_floor));
      if (i > int'(floor_q)) begin
        above = above | pend_q[i];
      end
      if (i < int'(floor_q)) begin
        below = below | pend_q[i];
      end
    end
  end

  assign here      = |(pend_q & cur_oh);
  assign nxt_hit   = |(pend_q & nxt_oh);
  assign call_here = |(bus.call_req & cur_oh);

  // scheduling decisions, clear mask and timer loads
  always_comb begin
    state_d     = state_q;
    clr         = '0;
    step        = 1'b0;
    travel_load = 1'b0;
    door_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (here) begin
          state_d   = DOOR;
          door_load = 1'b1;
          clr       = cur_oh;
        end else if (above && below) begin
          state_d     = (dir_q == UP) ? MOVE_UP : MOVE_DOWN;
          travel_load = 1'b1;
        end else if (above) begin
          state_d     = MOVE_UP;
          travel_load = 1'b1;
        end else if (below) begin
          state_d     = MOVE_DOWN;
          travel_load = 1'b1;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (travel_zero) begin
          step = 1'b1;
          if (nxt_hit) begin
            state_d   = DOOR;
            door_load = 1'b1;
            clr       = nxt_oh;
          end else begin
            travel_load = 1'b1;
          end
        end
      end
      DOOR: begin
        clr = cur_oh;
        if (call_here) begin
          door_load = 1'b1;
        end else if (door_zero) begin
          if (dir_q == UP) begin
            if (above) begin
              state_d     = MOVE_UP;
              travel_load = 1'b1;
            end else if (below) begin
              state_d     = MOVE_DOWN;
              travel_load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            if (below) begin
              state_d     = MOVE_DOWN;
              travel_load = 1'b1;
            end else if (above) begin
              state_d     = MOVE_UP;
              travel_load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
    endcase
  end

  // state, car position, last direction and latched calls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      floor_q <= '0;
      dir_q   <= UP;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= (pend_q | bus.call_req) & ~clr;
      if (step) begin
        floor_q <= nxt_floor;
        dir_q   <= (state_q == MOVE_DOWN) ? DOWN : UP;
      end
    end
  end

  down_timer #(.W(TW)) u_travel (
    .clk      (clk),
    .rst      (rst),
    .load     (travel_load),
    .load_val (TLOAD),
    .dec      (moving),
    .zero     (travel_zero)
  );

  down_timer #(.W(DW)) u_door (
    .clk      (clk),
    .rst      (rst),
    .load     (door_load),
    .load_val (DLOAD),
    .dec      (state_q == DOOR),
    .zero     (door_zero)
  );

  assign bus.cur_floor = floor_q;
  assign bus.move_up   = (state_q == MOVE_UP);
  assign bus.move_down = (state_q == MOVE_DOWN);
  assign bus.door_open = (state_q == DOOR);
  assign bus.busy      = (state_q != IDLE);
  assign bus.pending   = pend_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: scenario tasks plus a random run,
// checked against a floor/countdown model of the car.
module tb_elevator_scheduler;

  localparam int FLOORS = 8;
  localparam int TRAVEL = 4;
  localparam int DWELL  = 6;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  elevator_scheduler_if #(.FLOORS(8), .FLOOR_W(3)) bus ();

  elevator_scheduler #(
    .FLOORS(8), .FLOOR_W(3),
    .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks  = 0;
  int errors  = 0;
  int diverge = 0;
  logic [14:0] last_obs;
  logic [14:0] last_exp;

  int       m_pos;
  int       m_mode;
  int       m_dir;
  int       m_left;
  int       m_last;
  bit [7:0] m_pend;

  task automatic model_reset();
    m_pos  = 0;
    m_mode = M_IDLE;
    m_dir  = 1;
    m_left = 0;
    m_last = 1;
    m_pend = '0;
  endtask

  function automatic bit m_ahead(input int d);
    for (int f = 0; f < FLOORS; f++)
      if (m_pend[f] && (f - m_pos) * d > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_go(input int d);
    m_mode = M_MOVE;
    m_dir  = d;
    m_left = TRAVEL;
  endtask

  task automatic m_door();
    m_mode = M_DOOR;
    m_left = DWELL;
  endtask

  task automatic model_step(input bit [7:0] c);
    bit [7:0] clr = '0;
    case (m_mode)
      M_IDLE: begin
        if (m_pend[m_pos]) begin
          m_door();
          clr[m_pos] = 1'b1;
        end else if (m_ahead(1) && m_ahead(-1)) m_go(m_last);
        else if (m_ahead(1)) m_go(1);
        else if (m_ahead(-1)) m_go(-1);
      end
      M_MOVE: begin
        m_left--;
        if (m_left == 0) begin
          m_pos += m_dir;
          m_last = m_dir;
          if (m_pend[m_pos]) begin
            m_door();
            clr[m_pos] = 1'b1;
          end else m_left = TRAVEL;
        end
      end
      default: begin
        clr[m_pos] = 1'b1;
        if (c[m_pos]) m_left = DWELL;
        else begin
          m_left--;
          if (m_left == 0) begin
            if (m_ahead(m_last)) m_go(m_last);
            else if (m_ahead(-m_last)) m_go(-m_last);
            else m_mode = M_IDLE;
          end
        end
      end
    endcase
    m_pend = (m_pend | c) & ~clr;
  endtask

  function automatic logic [14:0] obs_vec();
    return {bus.busy, bus.door_open, bus.move_down, bus.move_up,
            bus.cur_floor, bus.pending};
  endfunction

  function automatic logic [14:0] exp_vec();
    return {m_mode != M_IDLE, m_mode == M_DOOR,
            m_mode == M_MOVE && m_dir < 0,
            m_mode == M_MOVE && m_dir > 0,
            3'(m_pos), m_pend};
  endfunction

  task automatic tick(input logic [7:0] c);
    bus.call_req = c;
    @(posedge clk);
    if (rst) model_step(c);
    else model_reset();
    #1;
    if (obs_vec() !== exp_vec()) begin
      diverge++;
      last_obs = obs_vec();
      last_exp = exp_vec();
    end
  endtask

  task automatic settle(input int max, output int cyc);
    cyc = 0;
    while ((bus.busy || bus.pending != 0) && cyc < max) begin
      tick(8'h00);
      cyc++;
    end
  endtask

  task automatic do_reset();
    bus.call_req = '0;
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int d0 = diverge;
    bus.call_req = '0;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick(8'hFF);
      checks++;
      if (obs_vec() !== 15'h0) begin
        errors++;
        $display("FAIL reset_hold: got %h want 0000", obs_vec());
      end
    end
    @(negedge clk);
    rst = 1'b1;
    tick(8'h00);
    checks++;
    if (obs_vec() !== 15'h0) begin
      errors++;
      $display("FAIL reset_release: got %h want 0000", obs_vec());
    end
    checks++;
    if (diverge != d0) begin
      errors++;
      $display("FAIL reset_model: got %h want %h", last_obs, last_exp);
    end
  endtask

  task automatic test_basic_trip();
    int d0 = diverge;
    int up_first = -1;
    int up_n = 0;
    int door_first = -1;
    int door_n = 0;
    int idle_at = -1;
    int floor_at_door = -1;
    tick(8'h08);
    checks++;
    if (bus.pending !== 8'h08 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL trip_latch: pending %h busy %b want 08 0",
               bus.pending, bus.busy);
    end
    for (int n = 1; n <= 22; n++) begin
      tick(8'h00);
      if (bus.move_up) begin
        if (up_first < 0) up_first = n;
        up_n++;
      end
      if (bus.door_open) begin
        if (door_first < 0) begin
          door_first = n;
          floor_at_door = int'(bus.cur_floor);
        end
        door_n++;
      end
      if (!bus.busy && door_n > 0 && idle_at < 0) idle_at = n;
    end
    checks++;
    if (up_first != 1 || up_n != 12) begin
      errors++;
      $display("FAIL trip_move: first %0d cycles %0d want 1 12",
               up_first, up_n);
    end
    checks++;
    if (door_first != 13 || door_n != 6 || floor_at_door != 3) begin
      errors++;
      $display("FAIL trip_door: first %0d cycles %0d floor %0d want 13 6 3",
               door_first, door_n, floor_at_door);
    end
    checks++;
    if (idle_at != 19 || bus.pending !== 8'h00) begin
      errors++;
      $display("FAIL trip_idle: idle %0d pending %h want 19 00",
               idle_at, bus.pending);
    end
    checks++;
    if (diverge != d0) begin
      errors++;
      $display("FAIL trip_model: got %h want %h", last_obs, last_exp);
    end
  endtask

  task automatic test_door_extension();
    int d0 = diverge;
    int dn = 0;
    int p3 = 0;
    bit ext = 1'b0;
    logic [7:0] c;
    tick(8'h08);
    for (int n = 0; n < 40; n++) begin
      c = (dn == 3 && !ext) ? 8'h08 : 8'h00;
      if (c != 0) ext = 1'b1;
      tick(c);
      if (bus.door_open) begin
        dn++;
        if (bus.pending[3]) p3++;
      end
      if (!bus.busy && bus.pending == 0) break;
    end
    checks++;
    if (dn != 9 || p3 != 0) begin
      errors++;
      $display("FAIL door_ext: cycles %0d pend3 %0d want 9 0", dn, p3);
    end
    checks++;
    if (diverge != d0) begin
      errors++;
      $display("FAIL door_model: got %h want %h", last_obs, last_exp);
    end
  endtask

  task automatic test_tie_break();
    int d0 = diverge;
    int cyc;
    tick(8'h40);
    settle(200, cyc);
    tick(8'h10);
    settle(200, cyc);
    checks++;
    if (cyc >= 200 || bus.cur_floor !== 3'd4) begin
      errors++;
      $display("FAIL tie_setup: floor %0d cyc %0d want 4 <200",
               bus.cur_floor, cyc);
    end
    tick(8'h44);
    tick(8'h00);
    checks++;
    if (bus.move_down !== 1'b1 || bus.move_up !== 1'b0) begin
      errors++;
      $display("FAIL tie_dir: down %b up %b want 1 0",
               bus.move_down, bus.move_up);
    end
    settle(300, cyc);
    checks++;
    if (cyc >= 300 || diverge != d0) begin
      errors++;
      $display("FAIL tie_model: got %h want %h cyc %0d",
               last_obs, last_exp, cyc);
    end
  endtask

  task automatic test_scan_order();
    int d0 = diverge;
    int cyc;
    int doors[$];
    bit found = 1'b0;
    bit prev = 1'b0;
    do_reset();
    tick(8'h20);
    for (int n = 0; n < 60; n++) begin
      if (bus.move_up && bus.cur_floor == 3'd2) begin
        found = 1'b1;
        break;
      end
      tick(8'h00);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL scan_reach: floor %0d want 2 moving up", bus.cur_floor);
    end
    tick(8'h02);
    for (int n = 0; n < 200; n++) begin
      if (!bus.busy && bus.pending == 0) break;
      tick(8'h00);
      if (bus.door_open && !prev) doors.push_back(int'(bus.cur_floor));
      prev = bus.door_open;
    end
    checks++;
    if (doors.size() != 2 || doors[0] != 5 || doors[1] != 1) begin
      errors++;
      $display("FAIL scan_order: stops %0d first %0d want 2 stops 5 then 1",
               doors.size(), (doors.size() > 0) ? doors[0] : -1);
    end
    tick(8'h09);
    tick(8'h00);
    checks++;
    if (bus.move_down !== 1'b1) begin
      errors++;
      $display("FAIL scan_lastdir: down %b want 1", bus.move_down);
    end
    settle(300, cyc);
    checks++;
    if (cyc >= 300 || diverge != d0) begin
      errors++;
      $display("FAIL scan_model: got %h want %h cyc %0d",
               last_obs, last_exp, cyc);
    end
  endtask

  task automatic test_bounds();
    int d0 = diverge;
    int up_n = 0;
    int mv_n = 0;
    int door_n = 0;
    int maxf = 0;
    do_reset();
    tick(8'h80);
    for (int n = 0; n < 100; n++) begin
      tick(8'h00);
      if (bus.move_up) up_n++;
      if (int'(bus.cur_floor) > maxf) maxf = int'(bus.cur_floor);
      if (!bus.busy && bus.pending == 0) break;
    end
    checks++;
    if (up_n != 28 || maxf != 7 || bus.cur_floor !== 3'd7) begin
      errors++;
      $display("FAIL bounds_top: up %0d max %0d floor %0d want 28 7 7",
               up_n, maxf, bus.cur_floor);
    end
    tick(8'h80);
    for (int n = 0; n < 40; n++) begin
      tick(8'h00);
      if (bus.move_up || bus.move_down) mv_n++;
      if (bus.door_open) door_n++;
      if (!bus.busy && bus.pending == 0) break;
    end
    checks++;
    if (mv_n != 0 || door_n != 6) begin
      errors++;
      $display("FAIL bounds_repeat: move %0d door %0d want 0 6",
               mv_n, door_n);
    end
    checks++;
    if (diverge != d0) begin
      errors++;
      $display("FAIL bounds_model: got %h want %h", last_obs, last_exp);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    do_reset();
    tick(8'h10);
    for (int n = 0; n < 60; n++) begin
      if (bus.move_up && bus.cur_floor == 3'd2) begin
        found = 1'b1;
        break;
      end
      tick(8'h00);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (!found || obs_vec() !== 15'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h want 0000 reached %b",
               obs_vec(), found);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    int d0 = diverge;
    int excl = 0;
    logic [7:0] c;
    for (int n = 0; n < 1500; n++) begin
      c = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      tick(c);
      if (32'(bus.move_up) + 32'(bus.move_down) + 32'(bus.door_open) > 1)
        excl++;
    end
    checks++;
    if (excl != 0) begin
      errors++;
      $display("FAIL rand_excl: overlaps %0d want 0", excl);
    end
    checks++;
    if (diverge != d0) begin
      errors++;
      $display("FAIL rand_model: diverged %0d got %h want %h",
               diverge - d0, last_obs, last_exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bus.call_req = '0;
    model_reset();
    test_reset();
    test_basic_trip();
    test_door_extension();
    test_tie_break();
    test_scan_order();
    test_bounds();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
